// File: rtl/branch_update_queue_if.sv
// Bundle between the EX-stage resolve logic and the branch update queue,
// including the predictor/BTB update outputs and the statistics counters.
interface branch_update_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_is_branch;
    logic                  in_is_jump;
    logic                  in_taken;
    logic                  in_mispredict;
    logic [DATA_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_target;
    logic                  upd_en;
    logic                  update_predictor;
    logic                  update_btb;
    logic                  actually_taken;
    logic [DATA_WIDTH-1:0] resolved_pc;
    logic [DATA_WIDTH-1:0] resolved_pc_target;
    logic                  empty;
    logic [CNT_WIDTH-1:0]  stat_branches;
    logic [CNT_WIDTH-1:0]  stat_mispredicts;

    // Queue side.
    modport slave (
        input  in_valid, in_is_branch, in_is_jump, in_taken, in_mispredict,
               in_pc, in_target, upd_en,
        output in_ready, update_predictor, update_btb, actually_taken,
               resolved_pc, resolved_pc_target, empty, stat_branches, stat_mispredicts
    );

    // Pipeline / branch-hardware side.
    modport master (
        output in_valid, in_is_branch, in_is_jump, in_taken, in_mispredict,
               in_pc, in_target, upd_en,
        input  in_ready, update_predictor, update_btb, actually_taken,
               resolved_pc, resolved_pc_target, empty, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_update_queue.sv
// In-order FIFO serialising branch/jump resolutions onto the predictor/BTB update port.
// Optional statistics counters enabled by defining BRANCH_UPDATE_STATS_EN.
module branch_update_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    branch_update_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic                  is_branch;
        logic                  taken;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] target;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PW:0]     count_q, count_d;
    logic            upd_pred_q, upd_btb_q, taken_q;
    logic [DATA_WIDTH-1:0] pc_q, tgt_q;

    logic   full, empty_w, accept, wr, pop;
    entry_t wr_entry, head_entry;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty_w = (count_q == '0);
    assign accept  = bus.in_valid && !full;
    // Non-control instructions complete the handshake but leave no entry.
    assign wr      = accept && (bus.in_is_branch || bus.in_is_jump);
    // Empty is registered state, so a same-edge write is never popped.
    assign pop     = !empty_w && bus.upd_en;

    assign wr_entry.is_branch = bus.in_is_branch && !bus.in_is_jump;
    assign wr_entry.taken     = bus.in_is_jump || bus.in_taken;
    assign wr_entry.pc        = bus.in_pc;
    assign wr_entry.target    = bus.in_target;
    assign head_entry         = mem_q[head_q];

    always_comb begin
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = wr  ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({wr, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[tail_q] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            upd_pred_q <= 1'b0;
            upd_btb_q  <= 1'b0;
            taken_q    <= 1'b0;
            pc_q       <= '0;
            tgt_q      <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            upd_pred_q <= pop && head_entry.is_branch;
            upd_btb_q  <= pop && head_entry.taken;
            if (pop) begin
                taken_q <= head_entry.taken;
                pc_q    <= head_entry.pc;
                tgt_q   <= head_entry.target;
            end
        end
    end

    assign bus.in_ready           = !full;
    assign bus.empty              = empty_w;
    assign bus.update_predictor   = upd_pred_q;
    assign bus.update_btb         = upd_btb_q;
    assign bus.actually_taken     = taken_q;
    assign bus.resolved_pc        = pc_q;
    assign bus.resolved_pc_target = tgt_q;

`ifdef BRANCH_UPDATE_STATS_EN
    logic [CNT_WIDTH-1:0] br_cnt_q, mp_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (wr && wr_entry.is_branch && br_cnt_q != '1)
                br_cnt_q <= br_cnt_q + CNT_WIDTH'(1);
            if (wr && bus.in_mispredict && mp_cnt_q != '1)
                mp_cnt_q <= mp_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.stat_branches    = br_cnt_q;
    assign bus.stat_mispredicts = mp_cnt_q;
`else
    logic unused_mispredict;
    assign unused_mispredict    = bus.in_mispredict;
    assign bus.stat_branches    = '0;
    assign bus.stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: latency, pulse encoding, back-pressure,
// ordering, non-control handshakes, mid-operation reset and statistics.
module tb_branch_update_queue;
    localparam int DW = 32;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cmp = 0;
    int   mis = 0;

    branch_update_queue_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    branch_update_queue #(.DATA_WIDTH(DW), .DEPTH(4), .CNT_WIDTH(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic br, input logic jmp, input logic tk,
                          input logic mp, input logic [DW-1:0] pc, input logic [DW-1:0] tgt);
        bus.in_valid      = v;
        bus.in_is_branch  = br;
        bus.in_is_jump    = jmp;
        bus.in_taken      = tk;
        bus.in_mispredict = mp;
        bus.in_pc         = pc;
        bus.in_target     = tgt;
    endtask

    // One-cycle presentation; the queue must have room.
    task automatic push(input logic br, input logic jmp, input logic tk, input logic mp,
                        input logic [DW-1:0] pc, input logic [DW-1:0] tgt);
        set_in(1'b1, br, jmp, tk, mp, pc, tgt);
        step();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        bus.upd_en = 1'b1;
        #12;
        cmp++; if (bus.empty !== 1'b1 || bus.in_ready !== 1'b1) begin
            mis++; $display("FAIL reset_flags: empty=%b in_ready=%b want 1 1", bus.empty, bus.in_ready); end
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            cmp++; if ({bus.update_predictor, bus.update_btb, bus.actually_taken} !== 3'b000 ||
                       bus.resolved_pc !== '0 || bus.resolved_pc_target !== '0 ||
                       bus.empty !== 1'b1 || bus.in_ready !== 1'b1) begin
                mis++; $display("FAIL reset_idle[%0d]: up=%b btb=%b tk=%b pc=%0h tgt=%0h empty=%b rdy=%b want all 0, empty/rdy 1",
                                i, bus.update_predictor, bus.update_btb, bus.actually_taken,
                                bus.resolved_pc, bus.resolved_pc_target, bus.empty, bus.in_ready); end
        end
    endtask

    task automatic test_single_taken;
        push(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h180);
        cmp++; if (bus.update_predictor !== 1'b0 || bus.empty !== 1'b0) begin
            mis++; $display("FAIL taken_no_bypass: up=%b empty=%b want 0 0", bus.update_predictor, bus.empty); end
        step();
        cmp++; if ({bus.update_predictor, bus.update_btb, bus.actually_taken} !== 3'b111 ||
                   bus.resolved_pc !== 32'h100 || bus.resolved_pc_target !== 32'h180) begin
            mis++; $display("FAIL taken_update: up/btb/tk=%b%b%b pc=%0h tgt=%0h want 111 100 180",
                            bus.update_predictor, bus.update_btb, bus.actually_taken,
                            bus.resolved_pc, bus.resolved_pc_target); end
        step();
        cmp++; if (bus.update_predictor !== 1'b0 || bus.update_btb !== 1'b0 ||
                   bus.resolved_pc !== 32'h100 || bus.empty !== 1'b1) begin
            mis++; $display("FAIL taken_after: up=%b btb=%b pc=%0h empty=%b want 0 0 100 1",
                            bus.update_predictor, bus.update_btb, bus.resolved_pc, bus.empty); end
    endtask

    task automatic test_not_taken_and_jump;
        push(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h204);
        push(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h400);
        cmp++; if ({bus.update_predictor, bus.update_btb, bus.actually_taken} !== 3'b100 ||
                   bus.resolved_pc !== 32'h200) begin
            mis++; $display("FAIL nt_branch: up/btb/tk=%b%b%b pc=%0h want 100 200",
                            bus.update_predictor, bus.update_btb, bus.actually_taken, bus.resolved_pc); end
        step();
        cmp++; if ({bus.update_predictor, bus.update_btb, bus.actually_taken} !== 3'b011 ||
                   bus.resolved_pc !== 32'h300 || bus.resolved_pc_target !== 32'h400) begin
            mis++; $display("FAIL jump: up/btb/tk=%b%b%b pc=%0h tgt=%0h want 011 300 400",
                            bus.update_predictor, bus.update_btb, bus.actually_taken,
                            bus.resolved_pc, bus.resolved_pc_target); end
        step();
    endtask

    task automatic test_back_to_back_full;
        bus.upd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmp++; if (bus.in_ready !== 1'b1) begin
                mis++; $display("FAIL fill_ready[%0d]: got %b want 1", i, bus.in_ready); end
            set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000 + 32'(4*i), 32'h2000 + 32'(i));
            step();
        end
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1010, 32'h2004);
        for (int i = 0; i < 2; i++) begin
            cmp++; if (bus.in_ready !== 1'b0 || bus.update_predictor !== 1'b0) begin
                mis++; $display("FAIL full_hold[%0d]: in_ready=%b up=%b want 0 0", i, bus.in_ready, bus.update_predictor); end
            step();
        end
        bus.upd_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) begin
                cmp++; if (bus.in_ready !== 1'b1) begin
                    mis++; $display("FAIL ready_after_pop: got %b want 1", bus.in_ready); end
            end
            if (k == 1) set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
            cmp++; if (bus.update_predictor !== 1'b1 || bus.resolved_pc !== 32'h1000 + 32'(4*k)) begin
                mis++; $display("FAIL drain[%0d]: up=%b pc=%0h want 1 %0h",
                                k, bus.update_predictor, bus.resolved_pc, 32'h1000 + 32'(4*k)); end
        end
        step();
        cmp++; if (bus.update_predictor !== 1'b0 || bus.empty !== 1'b1) begin
            mis++; $display("FAIL drain_end: up=%b empty=%b want 0 1", bus.update_predictor, bus.empty); end
    endtask

    task automatic test_non_control;
        cmp++; if (bus.in_ready !== 1'b1) begin
            mis++; $display("FAIL nonctl_ready: got %b want 1", bus.in_ready); end
        push(1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 32'h600);
        cmp++; if (bus.empty !== 1'b1) begin
            mis++; $display("FAIL nonctl_empty: got %b want 1", bus.empty); end
        step();
        cmp++; if (bus.update_predictor !== 1'b0 || bus.update_btb !== 1'b0 || bus.resolved_pc !== 32'h1010) begin
            mis++; $display("FAIL nonctl_pulse: up=%b btb=%b pc=%0h want 0 0 1010",
                            bus.update_predictor, bus.update_btb, bus.resolved_pc); end
    endtask

    task automatic test_reset_mid;
        bus.upd_en = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b1, 1'b0, 32'h700 + 32'(4*i), 32'h800);
        cmp++; if (bus.empty !== 1'b0) begin
            mis++; $display("FAIL mid_queued: empty=%b want 0", bus.empty); end
        #2 rstn = 1'b0;
        bus.upd_en = 1'b1;
        #1;
        cmp++; if (bus.empty !== 1'b1 || bus.in_ready !== 1'b1 || bus.resolved_pc !== '0 ||
                   bus.resolved_pc_target !== '0 || bus.actually_taken !== 1'b0) begin
            mis++; $display("FAIL mid_reset: empty=%b rdy=%b pc=%0h tgt=%0h tk=%b want 1 1 0 0 0",
                            bus.empty, bus.in_ready, bus.resolved_pc, bus.resolved_pc_target, bus.actually_taken); end
        step();
        #3 rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            cmp++; if (bus.update_predictor !== 1'b0 || bus.update_btb !== 1'b0 || bus.empty !== 1'b1) begin
                mis++; $display("FAIL post_reset[%0d]: up=%b btb=%b empty=%b want 0 0 1",
                                i, bus.update_predictor, bus.update_btb, bus.empty); end
        end
    endtask

    task automatic test_stats;
        push(1'b1, 1'b0, 1'b1, 1'b0, 32'h900, 32'h980);
        push(1'b1, 1'b0, 1'b0, 1'b1, 32'h904, 32'h908);
        push(1'b1, 1'b0, 1'b1, 1'b0, 32'h90c, 32'h990);
        push(1'b0, 1'b1, 1'b0, 1'b1, 32'h910, 32'ha00);
        push(1'b1, 1'b1, 1'b0, 1'b0, 32'h914, 32'hb00);
        push(1'b0, 1'b0, 1'b0, 1'b1, 32'h918, 32'h91c);
        for (int i = 0; i < 4; i++) step();
`ifdef BRANCH_UPDATE_STATS_EN
        cmp++; if (bus.stat_branches !== 32'd3 || bus.stat_mispredicts !== 32'd2) begin
            mis++; $display("FAIL stats: branches=%0d mispredicts=%0d want 3 2",
                            bus.stat_branches, bus.stat_mispredicts); end
`else
        cmp++; if (bus.stat_branches !== '0 || bus.stat_mispredicts !== '0) begin
            mis++; $display("FAIL stats_off: branches=%0d mispredicts=%0d want 0 0",
                            bus.stat_branches, bus.stat_mispredicts); end
`endif
        cmp++; if (bus.empty !== 1'b1 || bus.resolved_pc !== 32'h914 || bus.actually_taken !== 1'b1) begin
            mis++; $display("FAIL stats_drain: empty=%b pc=%0h tk=%b want 1 914 1",
                            bus.empty, bus.resolved_pc, bus.actually_taken); end
    endtask

    initial begin
        test_reset();
        test_single_taken();
        test_not_taken_and_jump();
        test_back_to_back_full();
        test_non_control();
        test_reset_mid();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- Buffers branch/jump resolutions from the EX stage in a small in-order FIFO.
- Serialises them onto the single update interface of the branch hardware (predictor + BTB): at most one update per cycle.
- Decouples EX-stage timing from predictor/BTB write timing and supplies back-pressure to the pipeline when full.
- Sits between EX-stage resolve logic and the branch hardware's update_predictor/update_btb/actually_taken/resolved_pc/resolved_pc_target inputs.

Parameters:
- DATA_WIDTH, 32, PC and target width.
- DEPTH, 4, number of FIFO entries; must be a power of 2, at least 2.
- CNT_WIDTH, 32, width of the statistics counters (optional feature).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rstn  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  EX stage presents a resolved control-flow instruction.
- in_ready  output  1  queue can accept; equals !full; combinational from state.
- in_is_branch  input  1  conditional branch.
- in_is_jump  input  1  unconditional jump (JAL/JALR).
- in_taken  input  1  actual direction; ignored for jumps, which are treated as taken.
- in_mispredict  input  1  front end mispredicted this instruction (statistics only).
- in_pc  input  DATA_WIDTH  PC of the resolved instruction.
- in_target  input  DATA_WIDTH  actual target address.
- upd_en  input  1  when low, no entry is popped (pauses updates).
- update_predictor  output  1  one-cycle pulse, drive predictor update.
- update_btb  output  1  one-cycle pulse, drive BTB update.
- actually_taken  output  1  outcome for the current update.
- resolved_pc  output  DATA_WIDTH  PC for the current update.
- resolved_pc_target  output  DATA_WIDTH  target for the current update.
- empty  output  1  FIFO holds no entries.
- stat_branches  output  CNT_WIDTH  resolved conditional branches accepted.
- stat_mispredicts  output  CNT_WIDTH  accepted entries with in_mispredict=1.

Behaviour:
- Reset (rstn low, asynchronous): head ptr, tail ptr and count cleared.
  - empty=1, in_ready=1.
  - update_predictor=0, update_btb=0, actually_taken=0, resolved_pc=0, resolved_pc_target=0.
  - Stat counters = 0.
  - Reset mid-operation discards all queued entries; no update pulse follows the reset.
- Accept: in_valid && in_ready at a rising edge.
  - If in_is_branch||in_is_jump, the entry {is_branch, taken_eff, pc, target} is written at tail, where taken_eff = in_is_jump | in_taken.
  - Otherwise the handshake completes and nothing is written.
  - If both in_is_branch and in_is_jump are set, treat as a jump.
- Pop: at a rising edge with !empty && upd_en, the head entry is removed and the output registers load from it.
  - update_predictor = is_branch.
  - update_btb = taken_eff; not-taken branches never update the BTB.
  - actually_taken = taken_eff; resolved_pc and resolved_pc_target are loaded from the entry.
- No pop at an edge: update_predictor and update_btb load 0; data outputs hold their last values.
- Latency: an entry written at edge E is popped no earlier than edge E+1; its pulse is high during cycle E+1..E+2. There is no bypass from input to output.
- Throughput: one pop per cycle.
- Ordering: strict FIFO; updates leave in acceptance order.
- Full: in_ready=0 when count==DEPTH.
  - Simultaneous pop while full does not raise in_ready in the same cycle (no pass-through).
  - in_valid while full is held off; there is no overflow.
- Empty: no pop, pulses 0. A simultaneous write and empty head is not popped at the same edge.
- Simultaneous accept and pop (not full, not empty): both occur; count unchanged.
- Pointers wrap modulo DEPTH; count is held in log2(DEPTH)+1 bits.
- upd_en low: queue fills normally; once upd_en returns high, pops resume from the oldest entry.

Optional Feature:
- Macro BRANCH_UPDATE_STATS_EN.
- Defined:
  - stat_branches increments on each accepted entry with in_is_branch=1 and in_is_jump=0.
  - stat_mispredicts increments on each accepted entry (branch or jump) with in_mispredict=1.
  - Both counters saturate at all-ones; both are reset by rstn.
- Undefined: both stat outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset, then idle 5 cycles -> empty=1, in_ready=1, all update outputs 0.
- Single taken branch, pc=0x100, target=0x180, accepted at edge E -> cycle after E+1 has update_predictor=1, update_btb=1, actually_taken=1, resolved_pc=0x100, resolved_pc_target=0x180; both pulses 0 the cycle after.
- Not-taken branch, pc=0x200 -> update_predictor=1, update_btb=0, actually_taken=0. Jump pc=0x300 with in_taken=0 -> update_predictor=0, update_btb=1, actually_taken=1.
- upd_en=0, push 5 branches back-to-back with DEPTH=4 -> in_ready=0 after the 4th accept and the 5th is held; raise upd_en -> 4 consecutive pulses with PCs in push order, then the 5th is accepted and updated.
- Non-control instruction (both flags 0) presented -> accepted, empty stays 1, no pulse.
- Assert rstn low with 3 entries queued -> outputs cleared immediately and no pulses after release. With BRANCH_UPDATE_STATS_EN: 3 branches, 1 with in_mispredict=1, plus 1 mispredicted jump -> stat_branches=3, stat_mispredicts=2.
